// File: rtl/jtpopeye_dwnld_pkg.sv
// Shared types and constants for the ROM download sequencer.
package jtpopeye_dwnld_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2,
    RUN  = 2'd3
  } state_t;

  // Bit positions of the regions inside the one-hot write strobe
  localparam int REG_MAIN    = 0;
  localparam int REG_CHAR    = 1;
  localparam int REG_OBJ     = 2;
  localparam int REG_PROM    = 3;
  localparam int NUM_REGIONS = 4;

  localparam int ADDR_W  = 22;
  localparam int LOCAL_W = 17;

  // Default Popeye ROM map
  localparam logic [ADDR_W-1:0] DEF_CHAR_START = 22'h08000;
  localparam logic [ADDR_W-1:0] DEF_OBJ_START  = 22'h09000;
  localparam logic [ADDR_W-1:0] DEF_PROM_START = 22'h11000;
  localparam logic [ADDR_W-1:0] DEF_ROM_END    = 22'h11240;
  localparam int                DEF_RST_HOLD   = 16;

endpackage

// File: rtl/jtpopeye_dwnld_if.sv
// HPS ioctl download bus: the frame wrapper drives it, the sequencer listens.
interface jtpopeye_dwnld_if;
  import jtpopeye_dwnld_pkg::*;

  logic              downloading;
  logic [ADDR_W-1:0] ioctl_addr;
  logic [7:0]        ioctl_data;
  logic              ioctl_wr;

  modport master (
    output downloading,
    output ioctl_addr,
    output ioctl_data,
    output ioctl_wr
  );

  modport slave (
    input downloading,
    input ioctl_addr,
    input ioctl_data,
    input ioctl_wr
  );

endinterface

// File: rtl/jtpopeye_dwnld_dec.sv
// Combinational region decoder: download address -> one-hot region,
// region-local offset and out-of-range flag.
module jtpopeye_dwnld_dec
  import jtpopeye_dwnld_pkg::*;
(
  input  logic [ADDR_W-1:0]      addr,
  input  logic [ADDR_W-1:0]      char_start,
  input  logic [ADDR_W-1:0]      obj_start,
  input  logic [ADDR_W-1:0]      prom_start,
  input  logic [ADDR_W-1:0]      rom_end,
  output logic [NUM_REGIONS-1:0] region,
  output logic [LOCAL_W-1:0]     offset,
  output logic                   oor
);

  logic [ADDR_W-1:0]  lo  [NUM_REGIONS];
  logic [ADDR_W-1:0]  hi  [NUM_REGIONS];
  logic [LOCAL_W-1:0] rel [NUM_REGIONS];

  // Regions are contiguous: each one ends where the next begins
  assign lo[REG_MAIN] = '0;
  assign hi[REG_MAIN] = char_start;
  assign lo[REG_CHAR] = char_start;
  assign hi[REG_CHAR] = obj_start;
  assign lo[REG_OBJ]  = obj_start;
  assign hi[REG_OBJ]  = prom_start;
  assign lo[REG_PROM] = prom_start;
  assign hi[REG_PROM] = rom_end;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGIONS; gi++) begin : g_region
      assign region[gi] = (addr >= lo[gi]) && (addr < hi[gi]);
      assign rel[gi]    = 17'(addr - lo[gi]);
    end
  endgenerate

  // Select the offset of whichever region matched (at most one does)
  always_comb begin
    offset = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (region[i]) offset = rel[i];
    end
  end

  assign oor = ~|region;

endmodule

// File: rtl/jtpopeye_dwnld.sv
// ROM download sequencer: routes ioctl bytes to the ROM banks, keeps the
// game in reset across a download and judges whether the image was complete.
module jtpopeye_dwnld
  import jtpopeye_dwnld_pkg::*;
#(
  parameter logic [ADDR_W-1:0] CHAR_START = DEF_CHAR_START,
  parameter logic [ADDR_W-1:0] OBJ_START  = DEF_OBJ_START,
  parameter logic [ADDR_W-1:0] PROM_START = DEF_PROM_START,
  parameter logic [ADDR_W-1:0] ROM_END    = DEF_ROM_END,
  parameter int                RST_HOLD   = DEF_RST_HOLD
) (
  input  logic                   clk,
  input  logic                   rst,
  jtpopeye_dwnld_if.slave        ioctl,
  output logic [LOCAL_W-1:0]     prog_addr,
  output logic [7:0]             prog_data,
  output logic [NUM_REGIONS-1:0] prog_we,
  output logic                   game_rst,
  output logic                   load_done,
  output logic                   load_err,
  output logic [15:0]            checksum
);

  localparam logic [15:0] HOLD_INIT = 16'(RST_HOLD - 1);

  state_t                 state_reg, state_next;
  logic [15:0]            hold_reg;
  logic [ADDR_W-1:0]      cnt_reg;
  logic [15:0]            sum_reg;
  logic                   done_reg, err_reg, oor_reg;
  logic [NUM_REGIONS-1:0] we_reg;
  logic [LOCAL_W-1:0]     addr_reg;
  logic [7:0]             data_reg;

  logic [NUM_REGIONS-1:0] dec_region;
  logic [LOCAL_W-1:0]     dec_offset;
  logic                   dec_oor;
  logic                   load_entry, accept, acc_ok, acc_bad, eval;

  jtpopeye_dwnld_dec u_dec (
    .addr       (ioctl.ioctl_addr),
    .char_start (CHAR_START),
    .obj_start  (OBJ_START),
    .prom_start (PROM_START),
    .rom_end    (ROM_END),
    .region     (dec_region),
    .offset     (dec_offset),
    .oor        (dec_oor)
  );

  // First cycle downloading is seen from outside LOAD restarts the image.
  // Bytes are taken for the whole of LOAD, which includes the cycle in
  // which downloading falls, so a trailing byte is never lost.
  assign load_entry = ioctl.downloading && (state_reg != LOAD);
  assign accept     = (state_reg == LOAD) && ioctl.ioctl_wr;
  assign acc_ok     = accept && !dec_oor;
  assign acc_bad    = accept && dec_oor;
  assign eval       = (state_reg == HOLD) && (state_next == RUN);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    state_next = ioctl.downloading ? LOAD : RUN;
      LOAD:    if (!ioctl.downloading) state_next = HOLD;
      HOLD: begin
        if (ioctl.downloading)   state_next = LOAD;
        else if (hold_reg == '0) state_next = RUN;
      end
      RUN:     if (ioctl.downloading) state_next = LOAD;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from state: the game only runs in RUN
  always_comb begin
    game_rst = (state_reg != RUN);
  end

  // Settle timer between the end of the transfer and game release
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_reg <= '0;
    end else if ((state_reg == LOAD) && !ioctl.downloading) begin
      hold_reg <= HOLD_INIT;
    end else if ((state_reg == HOLD) && (hold_reg != '0)) begin
      hold_reg <= hold_reg - 16'd1;
    end
  end

  // Byte count, checksum and image verdict
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg  <= '0;
      sum_reg  <= '0;
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
      oor_reg  <= 1'b0;
    end else if (load_entry) begin
      cnt_reg  <= '0;
      sum_reg  <= '0;
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
      oor_reg  <= 1'b0;
    end else begin
      if (acc_ok) begin
        if (!(&cnt_reg)) cnt_reg <= cnt_reg + 22'd1;
        sum_reg <= sum_reg + {8'd0, ioctl.ioctl_data};
      end
      if (acc_bad) oor_reg <= 1'b1;
      if (eval) begin
        if ((cnt_reg == ROM_END) && !oor_reg) done_reg <= 1'b1;
        else                                  err_reg  <= 1'b1;
      end
    end
  end

  // One-cycle write strobe; address/data hold between strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      we_reg   <= '0;
      addr_reg <= '0;
      data_reg <= '0;
    end else begin
      we_reg <= acc_ok ? dec_region : '0;
      if (acc_ok) begin
        addr_reg <= dec_offset;
        data_reg <= ioctl.ioctl_data;
      end
    end
  end

  assign prog_we   = we_reg;
  assign prog_addr = addr_reg;
  assign prog_data = data_reg;
  assign load_done = done_reg;
  assign load_err  = err_reg;
  assign checksum  = sum_reg;

endmodule

// File: tb/tb_jtpopeye_dwnld.sv
// Self-checking bench: a full-size instance for the real ROM map and a
// miniature instance for the corner cases, checked through a strobe
// scoreboard plus per-scenario status checks.
module tb_jtpopeye_dwnld;

  typedef struct {
    logic [3:0]  we;
    logic [16:0] addr;
    logic [7:0]  data;
    int          cyc;
  } exp_t;

  localparam int HOLD_BIG   = 16;
  localparam int HOLD_SMALL = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dl  = 1'b0;
  logic        wr  = 1'b0;
  logic [21:0] addr = '0;
  logic [7:0]  data = '0;
  int          sel = 0;
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  logic [15:0] exp_sum = '0;
  exp_t        q[$];
  exp_t        mon_e;

  logic [3:0]  we_w [2];
  logic [16:0] pa_w [2];
  logic [7:0]  pd_w [2];
  logic        gr_w [2];
  logic        ld_w [2];
  logic        le_w [2];
  logic [15:0] cs_w [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  jtpopeye_dwnld_if big_if ();
  jtpopeye_dwnld_if small_if ();

  assign big_if.downloading   = (sel == 0) && dl;
  assign big_if.ioctl_wr      = (sel == 0) && wr;
  assign big_if.ioctl_addr    = addr;
  assign big_if.ioctl_data    = data;
  assign small_if.downloading = (sel == 1) && dl;
  assign small_if.ioctl_wr    = (sel == 1) && wr;
  assign small_if.ioctl_addr  = addr;
  assign small_if.ioctl_data  = data;

  jtpopeye_dwnld u_big (
    .clk       (clk),
    .rst       (rst),
    .ioctl     (big_if),
    .prog_addr (pa_w[0]),
    .prog_data (pd_w[0]),
    .prog_we   (we_w[0]),
    .game_rst  (gr_w[0]),
    .load_done (ld_w[0]),
    .load_err  (le_w[0]),
    .checksum  (cs_w[0])
  );

  jtpopeye_dwnld #(
    .CHAR_START (22'h10),
    .OBJ_START  (22'h20),
    .PROM_START (22'h30),
    .ROM_END    (22'h40),
    .RST_HOLD   (HOLD_SMALL)
  ) u_small (
    .clk       (clk),
    .rst       (rst),
    .ioctl     (small_if),
    .prog_addr (pa_w[1]),
    .prog_data (pd_w[1]),
    .prog_we   (we_w[1]),
    .game_rst  (gr_w[1]),
    .load_done (ld_w[1]),
    .load_err  (le_w[1]),
    .checksum  (cs_w[1])
  );

  // Reference map of each instance; offset returned through 'off'
  function automatic logic [3:0] model_region(input int s, input logic [21:0] a,
                                              output logic [16:0] off);
    logic [21:0] c, o, p, e, base;
    logic [3:0]  r;
    if (s == 0) begin
      c = 22'h08000; o = 22'h09000; p = 22'h11000; e = 22'h11240;
    end else begin
      c = 22'h10; o = 22'h20; p = 22'h30; e = 22'h40;
    end
    r = 4'b0000; base = '0;
    if (a < c)      begin r = 4'b0001; base = '0; end
    else if (a < o) begin r = 4'b0010; base = c;  end
    else if (a < p) begin r = 4'b0100; base = o;  end
    else if (a < e) begin r = 4'b1000; base = p;  end
    off = 17'(a - base);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one ioctl byte for one cycle; 'acc' says whether the DUT should take it
  task automatic write_byte(input logic [21:0] a, input logic [7:0] d, input bit acc);
    logic [3:0]  r;
    logic [16:0] off;
    exp_t        e;
    addr = a; data = d; wr = 1'b1;
    r = model_region(sel, a, off);
    if (acc && (r != 4'b0000)) begin
      e.we = r; e.addr = off; e.data = d; e.cyc = cyc + 1;
      q.push_back(e);
      exp_sum = exp_sum + 16'(d);
    end
    tick();
  endtask

  // Ticks until game_rst falls; -1 if it never does within the bound
  task automatic wait_run(output int n);
    n = -1;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (gr_w[sel] == 1'b0) begin
        n = i;
        break;
      end
    end
  endtask

  // Strobe scoreboard, sampled mid-cycle
  always @(negedge clk) begin
    if (we_w[sel] !== 4'b0000) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe dut=%0d we=%b addr=%h data=%h required no strobe",
                 sel, we_w[sel], pa_w[sel], pd_w[sel]);
      end else begin
        mon_e = q.pop_front();
        if (we_w[sel] !== mon_e.we || pa_w[sel] !== mon_e.addr ||
            pd_w[sel] !== mon_e.data || cyc != mon_e.cyc) begin
          errors++;
          $display("FAIL strobe dut=%0d got we=%b addr=%h data=%h cyc=%0d required we=%b addr=%h data=%h cyc=%0d",
                   sel, we_w[sel], pa_w[sel], pd_w[sel], cyc,
                   mon_e.we, mon_e.addr, mon_e.data, mon_e.cyc);
        end else if (sel == 1 || mon_e.addr == 17'd0) begin
          $display("strobe dut=%0d we=%b addr=%h data=%h", sel, mon_e.we, mon_e.addr, mon_e.data);
        end
      end
    end
  end

  task automatic test_reset();
    sel = 0; rst = 1'b1; dl = 1'b0; wr = 1'b0;
    tick(); tick();
    checks += 7;
    if (we_w[0] !== 4'b0)  begin errors++; $display("FAIL rst_we got=%b required=0000", we_w[0]); end
    if (pa_w[0] !== 17'd0) begin errors++; $display("FAIL rst_addr got=%h required=0", pa_w[0]); end
    if (pd_w[0] !== 8'd0)  begin errors++; $display("FAIL rst_data got=%h required=0", pd_w[0]); end
    if (gr_w[0] !== 1'b1)  begin errors++; $display("FAIL rst_game_rst got=%b required=1", gr_w[0]); end
    if (ld_w[0] !== 1'b0)  begin errors++; $display("FAIL rst_done got=%b required=0", ld_w[0]); end
    if (le_w[0] !== 1'b0)  begin errors++; $display("FAIL rst_err got=%b required=0", le_w[0]); end
    if (cs_w[0] !== 16'd0) begin errors++; $display("FAIL rst_sum got=%h required=0", cs_w[0]); end
    rst = 1'b0;
    tick(); tick();
    // No download after reset: game released with nothing loaded
    checks += 2;
    if (gr_w[0] !== 1'b0) begin errors++; $display("FAIL idle_run got=%b required=0", gr_w[0]); end
    if (ld_w[0] !== 1'b0) begin errors++; $display("FAIL idle_done got=%b required=0", ld_w[0]); end
    $display("test_reset done");
  endtask

  task automatic test_full_image();
    int n;
    sel = 0; dl = 1'b1; exp_sum = '0;
    tick();
    for (int a = 0; a < 'h11240; a++) write_byte(22'(a), 8'(a), 1'b1);
    wr = 1'b0; dl = 1'b0;
    wait_run(n);
    // Low sampled at the first edge, then RST_HOLD more edges of hold
    checks += 6;
    if (n != HOLD_BIG + 1)  begin errors++; $display("FAIL full_hold got=%0d required=%0d", n, HOLD_BIG + 1); end
    if (ld_w[0] !== 1'b1)   begin errors++; $display("FAIL full_done got=%b required=1", ld_w[0]); end
    if (le_w[0] !== 1'b0)   begin errors++; $display("FAIL full_err got=%b required=0", le_w[0]); end
    if (cs_w[0] !== exp_sum) begin errors++; $display("FAIL full_sum got=%h required=%h", cs_w[0], exp_sum); end
    // 274 complete 0..FF passes (0x7F80 each) plus 0..3F, modulo 2^16
    if (cs_w[0] !== 16'h7EE0) begin errors++; $display("FAIL full_sum_const got=%h required=7ee0", cs_w[0]); end
    if (q.size() != 0) begin errors++; $display("FAIL full_missing got=%0d required=0", q.size()); end
    $display("test_full_image done sum=%h", cs_w[0]);
  endtask

  task automatic test_short_image();
    int n;
    sel = 0; dl = 1'b1; exp_sum = '0;
    tick();
    for (int a = 0; a < 'h1000; a++) write_byte(22'(a), 8'(a * 3), 1'b1);
    wr = 1'b0; dl = 1'b0;
    wait_run(n);
    checks += 5;
    if (n != HOLD_BIG + 1)   begin errors++; $display("FAIL short_hold got=%0d required=%0d", n, HOLD_BIG + 1); end
    if (le_w[0] !== 1'b1)    begin errors++; $display("FAIL short_err got=%b required=1", le_w[0]); end
    if (ld_w[0] !== 1'b0)    begin errors++; $display("FAIL short_done got=%b required=0", ld_w[0]); end
    if (cs_w[0] !== exp_sum) begin errors++; $display("FAIL short_sum got=%h required=%h", cs_w[0], exp_sum); end
    if (q.size() != 0) begin errors++; $display("FAIL short_missing got=%0d required=0", q.size()); end
    $display("test_short_image done");
  endtask

  task automatic test_rehold();
    int n;
    sel = 0; dl = 1'b1; exp_sum = '0;
    tick();
    for (int a = 0; a < 'h100; a++) write_byte(22'(a), 8'(a), 1'b1);
    wr = 1'b0; dl = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (gr_w[0] !== 1'b1) begin errors++; $display("FAIL rehold_hold_rst got=%b required=1", gr_w[0]); end
    end
    checks++;
    if (cs_w[0] !== exp_sum) begin errors++; $display("FAIL rehold_pre_sum got=%h required=%h", cs_w[0], exp_sum); end
    dl = 1'b1; exp_sum = '0;
    tick();
    checks += 4;
    if (gr_w[0] !== 1'b1)  begin errors++; $display("FAIL rehold_rst got=%b required=1", gr_w[0]); end
    if (cs_w[0] !== 16'd0) begin errors++; $display("FAIL rehold_sum_clr got=%h required=0", cs_w[0]); end
    if (ld_w[0] !== 1'b0)  begin errors++; $display("FAIL rehold_done got=%b required=0", ld_w[0]); end
    if (le_w[0] !== 1'b0)  begin errors++; $display("FAIL rehold_err got=%b required=0", le_w[0]); end
    for (int a = 0; a < 'h20; a++) write_byte(22'(a), 8'(a + 7), 1'b1);
    wr = 1'b0; dl = 1'b0;
    wait_run(n);
    checks += 3;
    if (n != HOLD_BIG + 1)   begin errors++; $display("FAIL rehold_hold got=%0d required=%0d", n, HOLD_BIG + 1); end
    if (le_w[0] !== 1'b1)    begin errors++; $display("FAIL rehold_final_err got=%b required=1", le_w[0]); end
    if (cs_w[0] !== exp_sum) begin errors++; $display("FAIL rehold_sum got=%h required=%h", cs_w[0], exp_sum); end
    $display("test_rehold done");
  endtask

  task automatic test_out_of_range();
    int n;
    sel = 1; dl = 1'b1; exp_sum = '0;
    tick();
    for (int a = 0; a < 'h40; a++) write_byte(22'(a), 8'($urandom_range(0, 255)), 1'b1);
    write_byte(22'h20000, 8'h55, 1'b1);
    wr = 1'b0; dl = 1'b0;
    wait_run(n);
    checks += 5;
    if (n != HOLD_SMALL + 1) begin errors++; $display("FAIL oor_hold got=%0d required=%0d", n, HOLD_SMALL + 1); end
    if (le_w[1] !== 1'b1)    begin errors++; $display("FAIL oor_err got=%b required=1", le_w[1]); end
    if (ld_w[1] !== 1'b0)    begin errors++; $display("FAIL oor_done got=%b required=0", ld_w[1]); end
    if (cs_w[1] !== exp_sum) begin errors++; $display("FAIL oor_sum got=%h required=%h", cs_w[1], exp_sum); end
    if (q.size() != 0) begin errors++; $display("FAIL oor_missing got=%0d required=0", q.size()); end
    $display("test_out_of_range done");
  endtask

  task automatic test_late_byte();
    int          n;
    logic [15:0] sum_run;
    sel = 1; dl = 1'b1; exp_sum = '0;
    tick();
    for (int a = 0; a < 'h3F; a++) write_byte(22'(a), 8'(a ^ 'h3C), 1'b1);
    dl = 1'b0;
    write_byte(22'h3F, 8'hE1, 1'b1);
    wr = 1'b0;
    wait_run(n);
    checks += 5;
    if (n != HOLD_SMALL)     begin errors++; $display("FAIL late_hold got=%0d required=%0d", n, HOLD_SMALL); end
    if (ld_w[1] !== 1'b1)    begin errors++; $display("FAIL late_done got=%b required=1", ld_w[1]); end
    if (le_w[1] !== 1'b0)    begin errors++; $display("FAIL late_err got=%b required=0", le_w[1]); end
    if (cs_w[1] !== exp_sum) begin errors++; $display("FAIL late_sum got=%h required=%h", cs_w[1], exp_sum); end
    if (q.size() != 0) begin errors++; $display("FAIL late_missing got=%0d required=0", q.size()); end
    // Writes while running are ignored
    sum_run = exp_sum;
    for (int a = 0; a < 3; a++) write_byte(22'(a), 8'hFF, 1'b0);
    wr = 1'b0;
    tick();
    checks += 2;
    if (cs_w[1] !== sum_run) begin errors++; $display("FAIL run_ignore_sum got=%h required=%h", cs_w[1], sum_run); end
    if (ld_w[1] !== 1'b1)    begin errors++; $display("FAIL run_ignore_done got=%b required=1", ld_w[1]); end
    $display("test_late_byte done");
  endtask

  task automatic test_mid_reset();
    int n;
    sel = 1; dl = 1'b1; exp_sum = '0;
    tick();
    for (int a = 0; a < 'h20; a++) write_byte(22'(a), 8'(a ^ 'hA5), 1'b1);
    wr = 1'b0; rst = 1'b1;
    tick();
    checks += 7;
    if (we_w[1] !== 4'b0)  begin errors++; $display("FAIL mrst_we got=%b required=0000", we_w[1]); end
    if (pa_w[1] !== 17'd0) begin errors++; $display("FAIL mrst_addr got=%h required=0", pa_w[1]); end
    if (pd_w[1] !== 8'd0)  begin errors++; $display("FAIL mrst_data got=%h required=0", pd_w[1]); end
    if (gr_w[1] !== 1'b1)  begin errors++; $display("FAIL mrst_game_rst got=%b required=1", gr_w[1]); end
    if (ld_w[1] !== 1'b0)  begin errors++; $display("FAIL mrst_done got=%b required=0", ld_w[1]); end
    if (le_w[1] !== 1'b0)  begin errors++; $display("FAIL mrst_err got=%b required=0", le_w[1]); end
    if (cs_w[1] !== 16'd0) begin errors++; $display("FAIL mrst_sum got=%h required=0", cs_w[1]); end
    rst = 1'b0; exp_sum = '0;
    tick();
    for (int a = 'h20; a < 'h40; a++) write_byte(22'(a), 8'(a ^ 'hA5), 1'b1);
    wr = 1'b0; dl = 1'b0;
    wait_run(n);
    checks += 5;
    if (n != HOLD_SMALL + 1) begin errors++; $display("FAIL mrst_hold got=%0d required=%0d", n, HOLD_SMALL + 1); end
    if (le_w[1] !== 1'b1)    begin errors++; $display("FAIL mrst_final_err got=%b required=1", le_w[1]); end
    if (ld_w[1] !== 1'b0)    begin errors++; $display("FAIL mrst_final_done got=%b required=0", ld_w[1]); end
    if (cs_w[1] !== exp_sum) begin errors++; $display("FAIL mrst_final_sum got=%h required=%h", cs_w[1], exp_sum); end
    if (q.size() != 0) begin errors++; $display("FAIL mrst_missing got=%0d required=0", q.size()); end
    $display("test_mid_reset done");
  endtask

  initial begin
    test_reset();
    test_full_image();
    test_short_image();
    test_rehold();
    test_out_of_range();
    test_late_byte();
    test_mid_reset();
    tick(); tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
